gain_ramp_limiter: RTL and testbench
====================================

# gain_ramp_limiter

- Output gain stage placed directly downstream of the reverb stage in the tulip DSP chain.
- Scales each signed sample by a per-sample ramped gain, which avoids zipper noise and pops on volume changes.
- Saturates the result to the sample width instead of wrapping, and counts clip events for software.
- 2-stage valid/ready pipeline with full throughput; bypass behaviour matches the other effect stages.

## Interface
- G_DATA_WIDTH, 16, signed sample width.
- G_GAIN_INTEGER_BITS, 2, integer bits of the unsigned gain.
- G_GAIN_DECIMAL_BITS, 14, fractional bits of the unsigned gain (gain format 2.14, 16 bits; 0x4000 = 1.0).
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  0 = synchronous flush/hold, 1 = run.
- bypass  in  1  1 = combinational passthrough.
- target_gain  in  16  unsigned 2.14 gain to ramp toward.
- ramp_step  in  16  unsigned 2.14 gain change per accepted sample; 0 = jump immediately.
- clip_clear  in  1  synchronous clear of clip_count.
- gain_current  out  16  gain applied to the next accepted sample.
- ramp_active  out  1  state != HOLD.
- clip_count  out  16  saturating count of clipped samples.
- din  in  G_DATA_WIDTH  signed input sample.
- din_valid  in  1
- din_ready  out  1
- dout  out  G_DATA_WIDTH  signed, saturated output sample.
- dout_valid  out  1
- dout_ready  in  1

## Operation
- Ramp FSM (registered): HOLD, RAMP_UP, RAMP_DOWN. Reset state HOLD, gain_current = 0, so the stage fades in after reset.
- Gain update happens only on an accepted sample (din_valid & din_ready, bypass = 0, enable = 1). The sample uses the old gain_current; the new gain takes effect for the next sample.
  - gain_current < target_gain: gain_next = min(gain_current + ramp_step, target_gain).
  - gain_current > target_gain: gain_next = max(gain_current - ramp_step, target_gain).
  - Compute in 17 bits; no wrap.
  - ramp_step = 0: gain_next = target_gain.
  - State after the update: HOLD if gain_next == target_gain, else RAMP_UP or RAMP_DOWN.
  - If target_gain changes mid-ramp, direction is re-evaluated on the next accepted sample.
  - In HOLD with target_gain != gain_current: state moves to RAMP_* on the next clock without a gain change. ramp_active may therefore lag a target change by 1 cycle.
- Stage 1 register: product = din * signed'({1'b0, gain_current}), 33 bits.
- Stage 2 register:
  - shifted = product >>> 14 (arithmetic; floors toward −inf).
  - Clamp to [−32768, 32767].
  - If a clamp occurred when loading dout, clip_count increments, saturating at 0xFFFF.
  - clip_clear has priority over a simultaneous increment; the result is 0.
- enable = 0:
  - din_ready = 0, both pipeline valids cleared next clock, in-flight samples dropped.
  - gain_current = 0, state HOLD.
  - clip_count retained.
- bypass = 1:
  - dout = din, dout_valid = din_valid, din_ready = dout_ready (combinational).
  - Pipeline valids cleared; gain, state and clip_count held.
  - Switching bypass with data in flight drops that data; software switches only when idle.

## Timing
- Reset values of outputs: dout = 0, dout_valid = 0, din_ready = 0 while reset asserted, gain_current = 0, ramp_active = 0, clip_count = 0.
- Latency: a sample accepted in cycle N appears on dout with dout_valid in cycle N+2.
- Pipeline advance: advance = ~dout_valid | dout_ready. This is a global stall; both stages move together.
- din_ready = enable & ~bypass & advance. With dout_ready held high, throughput is 1 sample/cycle.
- dout_valid/dout are held stable while dout_ready = 0. No sample is lost or duplicated under backpressure.
- The pipeline holds at most 2 samples.
- Async reset asserted mid-stream: all state clears immediately, and in-flight samples are lost.

## Test plan
- Fade-in from reset: target = 0x4000, step = 0x1000, din = 1000 ×6 → dout 0, 250, 500, 750, 1000, 1000. ramp_active deasserts after the 4th acceptance; gain_current = 0x4000.
- Saturation: step = 0, target = 0xC000 (3.0), din = 20000, −20000, 100 → dout 32767, −32768, 300. clip_count = 2; clip_clear pulse → clip_count = 0.
- Backpressure: gain 1.0, din 1..10 continuous, dout_ready low for 5 cycles mid-burst → din_ready drops once 2 samples are held. Output is exactly 1..10 in order, dout stable while stalled.
- Retarget mid-ramp: ramping 0x0000→0x4000, step 0x0800, target changed to 0x1000 when gain = 0x2000 → gain 0x1800, 0x1000, then HOLD.
- Bypass/enable: bypass = 1, din = −5 → dout = −5 in the same cycle, gain unchanged. enable low for 1 cycle with 2 samples in flight → dout_valid = 0, gain_current = 0.
- Async reset low mid-burst → all outputs take reset values without a clock edge; operation resumes cleanly after release.

Source files
------------

// File: rtl/gain_ramp_limiter.sv
// Output gain stage: ramps a 2.14 gain toward a target one step per accepted sample,
// multiplies, floors and saturates to the sample width, and counts clipped samples.
module gain_ramp_limiter #(
  parameter int unsigned G_DATA_WIDTH        = 16,
  parameter int unsigned G_GAIN_INTEGER_BITS = 2,
  parameter int unsigned G_GAIN_DECIMAL_BITS = 14
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  enable,
  input  logic                                                  bypass,
  input  logic [G_GAIN_INTEGER_BITS+G_GAIN_DECIMAL_BITS-1:0]    target_gain,
  input  logic [G_GAIN_INTEGER_BITS+G_GAIN_DECIMAL_BITS-1:0]    ramp_step,
  input  logic                                                  clip_clear,
  output logic [G_GAIN_INTEGER_BITS+G_GAIN_DECIMAL_BITS-1:0]    gain_current,
  output logic                                                  ramp_active,
  output logic [15:0]                                           clip_count,
  input  logic signed [G_DATA_WIDTH-1:0]                        din,
  input  logic                                                  din_valid,
  output logic                                                  din_ready,
  output logic signed [G_DATA_WIDTH-1:0]                        dout,
  output logic                                                  dout_valid,
  input  logic                                                  dout_ready
);

  localparam int unsigned GW = G_GAIN_INTEGER_BITS + G_GAIN_DECIMAL_BITS;
  localparam int unsigned PW = G_DATA_WIDTH + GW + 1;
  localparam logic signed [PW-1:0] SatMax =
    {{(PW - G_DATA_WIDTH + 1){1'b0}}, {(G_DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] SatMin =
    {{(PW - G_DATA_WIDTH + 1){1'b1}}, {(G_DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StHold, StRampUp, StRampDown} state_e;

  state_e                         state_q, state_d;
  logic [GW-1:0]                  gain_q, gain_d;
  logic                           s1_valid_q, s1_valid_d;
  logic signed [PW-1:0]           prod_q, prod_d;
  logic                           s2_valid_q, s2_valid_d;
  logic signed [G_DATA_WIDTH-1:0] dout_q, dout_d;
  logic [15:0]                    clip_q, clip_d;

  logic                           byp, advance, accept;
  logic [GW:0]                    gain_sum, gain_diff;
  logic [GW-1:0]                  gain_next;
  logic signed [PW-1:0]           din_ext, gain_ext, prod_new, shifted;
  logic                           sat_hi, sat_lo;
  logic signed [G_DATA_WIDTH-1:0] dout_sat;

  // Gating with reset keeps every output at its reset value while reset is held.
  assign byp       = bypass & reset;
  assign advance   = ~s2_valid_q | dout_ready;
  assign din_ready = reset & (bypass ? dout_ready : (enable & advance));
  assign accept    = din_valid & din_ready & ~bypass;

  always_comb begin
    gain_sum  = {1'b0, gain_q} + {1'b0, ramp_step};
    gain_diff = {1'b0, gain_q} - {1'b0, ramp_step};
    gain_next = target_gain;
    if (ramp_step != '0) begin
      if (gain_q < target_gain) begin
        gain_next = (gain_sum > {1'b0, target_gain}) ? target_gain : gain_sum[GW-1:0];
      end else if (gain_q > target_gain) begin
        gain_next = (gain_diff[GW] || (gain_diff[GW-1:0] < target_gain)) ?
                    target_gain : gain_diff[GW-1:0];
      end
    end
  end

  always_comb begin
    din_ext  = {{(PW - G_DATA_WIDTH){din[G_DATA_WIDTH-1]}}, din};
    gain_ext = {{(PW - GW){1'b0}}, gain_q};
    prod_new = din_ext * gain_ext;
    shifted  = prod_q >>> G_GAIN_DECIMAL_BITS;
    sat_hi   = shifted > SatMax;
    sat_lo   = shifted < SatMin;
    if (sat_hi) begin
      dout_sat = SatMax[G_DATA_WIDTH-1:0];
    end else if (sat_lo) begin
      dout_sat = SatMin[G_DATA_WIDTH-1:0];
    end else begin
      dout_sat = shifted[G_DATA_WIDTH-1:0];
    end
  end

  // Ramp FSM: gain only moves on an accepted sample; HOLD notices a new target on its own.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (!enable) begin
      state_d = StHold;
      gain_d  = '0;
    end else if (!bypass) begin
      if (accept) begin
        gain_d = gain_next;
        if (gain_next == target_gain) begin
          state_d = StHold;
        end else if (gain_next < target_gain) begin
          state_d = StRampUp;
        end else begin
          state_d = StRampDown;
        end
      end else if (state_q == StHold && target_gain != gain_q) begin
        state_d = (target_gain > gain_q) ? StRampUp : StRampDown;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    prod_d     = prod_q;
    dout_d     = dout_q;
    clip_d     = clip_q;
    if (!enable || bypass) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else if (advance) begin
      s1_valid_d = accept;
      s2_valid_d = s1_valid_q;
      if (accept) begin
        prod_d = prod_new;
      end
      if (s1_valid_q) begin
        dout_d = dout_sat;
        if ((sat_hi || sat_lo) && clip_q != '1) begin
          clip_d = clip_q + 16'd1;
        end
      end
    end
    if (clip_clear) begin
      clip_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StHold;
      gain_q     <= '0;
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
      s2_valid_q <= 1'b0;
      dout_q     <= '0;
      clip_q     <= '0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      s1_valid_q <= s1_valid_d;
      prod_q     <= prod_d;
      s2_valid_q <= s2_valid_d;
      dout_q     <= dout_d;
      clip_q     <= clip_d;
    end
  end

  assign dout         = byp ? din : dout_q;
  assign dout_valid   = byp ? din_valid : s2_valid_q;
  assign gain_current = gain_q;
  assign ramp_active  = (state_q != StHold);
  assign clip_count   = clip_q;

endmodule

// File: tb/tb_gain_ramp_limiter.sv
// Scoreboard bench for gain_ramp_limiter: expected samples are queued on acceptance and
// checked when the DUT hands them out; each scenario task also checks gain/state/count.
module tb_gain_ramp_limiter;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               bypass;
  logic [15:0]        target_gain;
  logic [15:0]        ramp_step;
  logic               clip_clear;
  logic [15:0]        gain_current;
  logic               ramp_active;
  logic [15:0]        clip_count;
  logic signed [15:0] din;
  logic               din_valid;
  logic               din_ready;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [15:0] exp_q[$];
  logic               mon_en = 1'b0;
  logic               stall_seen = 1'b0;
  logic signed [15:0] stall_dout = '0;

  gain_ramp_limiter dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bypass       (bypass),
    .target_gain  (target_gain),
    .ramp_step    (ramp_step),
    .clip_clear   (clip_clear),
    .gain_current (gain_current),
    .ramp_active  (ramp_active),
    .clip_count   (clip_count),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (mon_en && reset && !bypass) begin
      if (stall_seen && dout_valid) begin
        n_cmp++;
        if (dout !== stall_dout) begin
          n_bad++;
          $display("FAIL stall_stable: dout=%0d held_value=%0d", dout, stall_dout);
        end
      end
      if (dout_valid && dout_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: dout=%0d with no sample outstanding", dout);
        end else begin
          logic signed [15:0] e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            n_bad++;
            $display("FAIL dout_sample: got=%0d expected=%0d", dout, e);
          end
        end
      end
      stall_seen = dout_valid && !dout_ready;
      stall_dout = dout;
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [15:0] ref_out(input int x, input int g);
    longint p;
    p = longint'(x) * longint'(g);
    p = p >>> 14;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  task automatic send(input logic signed [15:0] x, input logic signed [15:0] e);
    logic done;
    done = 1'b0;
    din = x;
    din_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (din_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: din=%0d never accepted", x);
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d samples outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; bypass = 1'b0; clip_clear = 1'b0;
    target_gain = 16'h4000; ramp_step = 16'h1000;
    din = 16'sd1234; din_valid = 1'b1; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 6;
    if (dout !== 16'sd0)      begin n_bad++; $display("FAIL rst_dout: got=%0d req=0", dout); end
    if (dout_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_dout_valid: got=%b req=0", dout_valid); end
    if (din_ready !== 1'b0)   begin n_bad++; $display("FAIL rst_din_ready: got=%b req=0", din_ready); end
    if (gain_current !== 16'h0) begin n_bad++; $display("FAIL rst_gain: got=%h req=0", gain_current); end
    if (ramp_active !== 1'b0) begin n_bad++; $display("FAIL rst_ramp: got=%b req=0", ramp_active); end
    if (clip_count !== 16'h0) begin n_bad++; $display("FAIL rst_clip: got=%h req=0", clip_count); end
    din_valid = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_fade_in();
    logic signed [15:0] eo[6] = '{16'sd0, 16'sd250, 16'sd500, 16'sd750, 16'sd1000, 16'sd1000};
    logic [15:0]        eg[6] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h4000, 16'h4000};
    logic               er[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    n_cmp++;
    if (ramp_active !== 1'b1) begin
      n_bad++; $display("FAIL fade_ramp_start: got=%b req=1", ramp_active);
    end
    for (int i = 0; i < 6; i++) begin
      send(16'sd1000, eo[i]);
      n_cmp += 2;
      if (gain_current !== eg[i]) begin
        n_bad++; $display("FAIL fade_gain[%0d]: got=%h req=%h", i, gain_current, eg[i]);
      end
      if (ramp_active !== er[i]) begin
        n_bad++; $display("FAIL fade_ramp[%0d]: got=%b req=%b", i, ramp_active, er[i]);
      end
    end
    drain();
  endtask

  task automatic test_saturation();
    ramp_step = 16'h0000;
    target_gain = 16'hC000;
    send(16'sd0, 16'sd0);
    send(16'sd20000, 16'sd32767);
    send(-16'sd20000, -16'sd32768);
    send(16'sd100, 16'sd300);
    drain();
    n_cmp++;
    if (clip_count !== 16'd2) begin
      n_bad++; $display("FAIL clip_count: got=%0d req=2", clip_count);
    end
    clip_clear = 1'b1;
    @(posedge clk);
    #1;
    clip_clear = 1'b0;
    n_cmp++;
    if (clip_count !== 16'd0) begin
      n_bad++; $display("FAIL clip_clear: got=%0d req=0", clip_count);
    end
    // Half gain on odd negatives exercises the floor toward minus infinity.
    target_gain = 16'h2000;
    send(16'sd0, 16'sd0);
    send(-16'sd1, -16'sd1);
    send(16'sd1, 16'sd0);
    send(-16'sd3, -16'sd2);
    drain();
    n_cmp++;
    if (clip_count !== 16'd0) begin
      n_bad++; $display("FAIL clip_no_clip: got=%0d req=0", clip_count);
    end
  endtask

  task automatic test_back_to_back();
    target_gain = 16'h4000;
    ramp_step = 16'h0000;
    send(16'sd0, 16'sd0);
    fork
      begin
        for (int i = 1; i <= 10; i++) send(16'(i), 16'(i));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp += 2;
        if (din_ready !== 1'b0) begin
          n_bad++; $display("FAIL bp_din_ready: got=%b req=0", din_ready);
        end
        if (dout_valid !== 1'b1) begin
          n_bad++; $display("FAIL bp_dout_valid: got=%b req=1", dout_valid);
        end
        repeat (4) @(posedge clk);
        #1;
        dout_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_retarget();
    int          gu[6] = '{32'h0000, 32'h0800, 32'h1000, 32'h1800, 32'h2000, 32'h1800};
    logic [15:0] eg[6] = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h1800, 16'h1000};
    logic        er[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    target_gain = 16'h4000;
    ramp_step = 16'h0800;
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    n_cmp++;
    if (gain_current !== 16'h0) begin
      n_bad++; $display("FAIL rt_start_gain: got=%h req=0", gain_current);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 4) target_gain = 16'h1000;
      send(16'sd100, ref_out(100, gu[i]));
      n_cmp += 2;
      if (gain_current !== eg[i]) begin
        n_bad++; $display("FAIL rt_gain[%0d]: got=%h req=%h", i, gain_current, eg[i]);
      end
      if (ramp_active !== er[i]) begin
        n_bad++; $display("FAIL rt_ramp[%0d]: got=%b req=%b", i, ramp_active, er[i]);
      end
    end
    drain();
  endtask

  task automatic test_bypass_enable();
    bypass = 1'b1;
    din = -16'sd5;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    #1;
    n_cmp += 3;
    if (dout !== -16'sd5)    begin n_bad++; $display("FAIL byp_dout: got=%0d req=-5", dout); end
    if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL byp_valid: got=%b req=1", dout_valid); end
    if (din_ready !== 1'b1)  begin n_bad++; $display("FAIL byp_ready: got=%b req=1", din_ready); end
    dout_ready = 1'b0;
    #1;
    n_cmp++;
    if (din_ready !== 1'b0) begin n_bad++; $display("FAIL byp_ready_low: got=%b req=0", din_ready); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (gain_current !== 16'h1000) begin
      n_bad++; $display("FAIL byp_gain_held: got=%h req=1000", gain_current);
    end
    bypass = 1'b0;
    din = 16'sd50;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (din_ready !== 1'b1) begin
        n_bad++; $display("FAIL en_fill_ready[%0d]: got=%b req=1", i, din_ready);
      end
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    n_cmp += 3;
    if (dout_valid !== 1'b0)    begin n_bad++; $display("FAIL en_flush_valid: got=%b req=0", dout_valid); end
    if (gain_current !== 16'h0) begin n_bad++; $display("FAIL en_gain: got=%h req=0", gain_current); end
    if (din_ready !== 1'b0)     begin n_bad++; $display("FAIL en_ready: got=%b req=0", din_ready); end
    enable = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL en_dropped: got=%b req=0", dout_valid); end
  endtask

  task automatic test_async_reset();
    target_gain = 16'hC000;
    ramp_step = 16'h0000;
    send(16'sd0, 16'sd0);
    send(16'sd20000, 16'sd32767);
    drain();
    n_cmp++;
    if (clip_count !== 16'd1) begin n_bad++; $display("FAIL ar_clip_pre: got=%0d req=1", clip_count); end
    mon_en = 1'b0;
    din = 16'sd1;
    din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_cmp += 6;
    if (dout !== 16'sd0)        begin n_bad++; $display("FAIL ar_dout: got=%0d req=0", dout); end
    if (dout_valid !== 1'b0)    begin n_bad++; $display("FAIL ar_valid: got=%b req=0", dout_valid); end
    if (din_ready !== 1'b0)     begin n_bad++; $display("FAIL ar_ready: got=%b req=0", din_ready); end
    if (gain_current !== 16'h0) begin n_bad++; $display("FAIL ar_gain: got=%h req=0", gain_current); end
    if (ramp_active !== 1'b0)   begin n_bad++; $display("FAIL ar_ramp: got=%b req=0", ramp_active); end
    if (clip_count !== 16'h0)   begin n_bad++; $display("FAIL ar_clip: got=%h req=0", clip_count); end
    exp_q.delete();
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
    send(16'sd0, 16'sd0);
    send(16'sd7, 16'sd21);
    send(-16'sd9, -16'sd27);
    drain();
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_saturation();
    test_back_to_back();
    test_retarget();
    test_bypass_enable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
